mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream controller for the 4:1 multiplexer. It drives the mux select, steps through the enabled
//   inputs, samples the mux output after a settle time and assembles the four samples into a 4-bit word.
//   The word is delivered on a valid/ready handshake.
//   Supports one-shot scans on request, and continuous scanning that runs until stopped.
// PARAMETERS
//   SETTLE      1  cycles S is held per channel before Y is sampled (legal range 1..15)
//   CONTINUOUS  0  0 = one scan per start; 1 = auto-restart after each scan until stop
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  scan request, level-sampled on clk
//   stop        in   1  CONTINUOUS=1 only: finish current scan, then return to IDLE
//   ch_mask     in   4  channel enable, bit k = mux input k; latched at scan start
//   S           out  2  select to mux
//   Y           in   1  mux output
//   busy        out  1  scan in progress
//   data_out    out  4  bit k = sampled Y of channel k; 0 for masked-off channels
//   data_valid  out  1  data_out holds an unconsumed result
//   data_ready  in   1  consumer accepts result
//   overrun     out  1  one-cycle pulse: unconsumed result overwritten (CONTINUOUS=1)
// BEHAVIOUR
//   - Reset (async, immediate): S=00, busy=0, data_out=0000, data_valid=0, overrun=0, FSM=IDLE,
//     settle counter=0, latched mask=0000, stop-pending=0.
//   - FSM states and transitions:
//       IDLE -> SCAN when start=1 and data_valid=0. When data_valid=1, start is ignored (not queued).
//       SCAN -> IDLE at the last sample edge when CONTINUOUS=0, or when CONTINUOUS=1 and stop was seen.
//       SCAN -> SCAN (restart) at the last sample edge otherwise.
//   - Start edge e0 (effects at e0):
//       latch ch_mask; ch_mask=0000 is treated as 1111;
//       S <= lowest enabled channel; busy <= 1; shadow register <= 0000.
//   - Channel order: enabled channels in ascending index; disabled channels are never selected.
//   - Sampling:
//       * The channel selected at edge t has Y sampled at edge t+SETTLE into shadow bit k.
//       * The same edge moves S to the next enabled channel.
//       * With n enabled channels, the last sample edge is e0 + n*SETTLE.
//   - At the last sample edge:
//       * data_out <= shadow, including the final Y bit.
//       * data_valid <= 1.
//       * CONTINUOUS=0: busy <= 0 and S holds the last channel.
//       * CONTINUOUS=1 and no stop pending: S <= first enabled channel, busy stays 1, and
//         the next scan starts with no idle cycle, using the same latched mask.
//   - Handshake:
//       * data_out is stable while data_valid=1.
//       * Transfer happens at an edge with data_valid & data_ready; data_valid <= 0 at that edge.
//       * data_ready is ignored while data_valid=0.
//   - Simultaneous events:
//       * Transfer and new result on the same edge: the new result wins. data_valid stays 1, overrun=0.
//       * New result while data_valid=1 and no transfer: data_out is overwritten and overrun pulses for 1 cycle.
//         This occurs only when CONTINUOUS=1, because one-shot cannot start while data_valid=1.
//   - stop:
//       * Sampled every cycle in SCAN and sets stop-pending.
//       * The current scan completes normally and the FSM enters IDLE with busy=0.
//       * stop-pending clears on entry to IDLE.
//       * stop is ignored in IDLE and when CONTINUOUS=0.
//   - start while busy is ignored.
//   - ch_mask changes mid-scan have no effect until the next start (continuous scans keep their latched mask).
//   - Reset mid-scan: the partial result is discarded and no data_valid is produced.
//   - Settle counter is 4 bits and wraps to 0 at each channel advance.
// TESTING
//   1 SETTLE=1, mask=1111, I=1010 (Y follows S), start at e0 -> S 0,1,2,3 at e0..e0+3;
//     data_out=1010, data_valid at e0+4, busy low at e0+4.
//   2 SETTLE=3, mask=0101, I=1111 -> S visits only 0 and 2; data_out=0101; data_valid at e0+6.
//   3 Hold data_ready=0, then pulse start again (CONTINUOUS=0) -> no new scan, data_out held;
//     raise data_ready -> data_valid drops next edge; a subsequent start is accepted.
//   4 CONTINUOUS=1, mask=1111, SETTLE=1, data_ready=0, I changes 0011->1100 during scan 2
//     -> overrun pulses at end of scan 2; data_out reflects scan 2; S wraps 3->0 with no gap.
//   5 CONTINUOUS=1, assert stop mid-scan -> scan completes, busy=0, FSM idle, no further S activity.
//   6 Assert rst mid-scan (S=2) -> all outputs reset immediately; data_valid never asserts for that scan.
//     A start after release runs a full clean scan.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux: steps the select over enabled channels, samples Y after a settle
// time and delivers the assembled 4-bit word on a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE     = 1,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] ch_mask,
    output logic [1:0] S,
    input  logic       Y,
    output logic       busy,
    output logic [3:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state_r, state_s;
    logic [3:0] mask_r, mask_s;
    logic [3:0] cnt_r, cnt_s;
    logic [1:0] sel_r, sel_s;
    logic [3:0] shadow_r, shadow_s;
    logic [3:0] dout_r, dout_s;
    logic       valid_r, valid_s;
    logic       overrun_r, overrun_s;
    logic       busy_r, busy_s;
    logic       stop_pend_r, stop_pend_s;

    logic [3:0] shadow_smp_s;
    logic [3:0] above_s;
    logic [3:0] eff_mask_s;

    function automatic logic [1:0] first_ch(input logic [3:0] m);
        if (m[0]) begin
            first_ch = 2'd0;
        end else if (m[1]) begin
            first_ch = 2'd1;
        end else if (m[2]) begin
            first_ch = 2'd2;
        end else begin
            first_ch = 2'd3;
        end
    endfunction

    // Next-state, datapath and handshake logic
    always_comb begin
        state_s      = state_r;
        mask_s       = mask_r;
        cnt_s        = cnt_r;
        sel_s        = sel_r;
        shadow_s     = shadow_r;
        dout_s       = dout_r;
        valid_s      = valid_r;
        overrun_s    = 1'b0;
        busy_s       = busy_r;
        stop_pend_s  = stop_pend_r;
        shadow_smp_s = shadow_r;
        shadow_smp_s[sel_r] = Y;
        // channels strictly above the current select that are still enabled
        above_s      = mask_r & ~((4'b0010 << sel_r) - 4'b0001);
        eff_mask_s   = (ch_mask == 4'b0000) ? 4'b1111 : ch_mask;

        if (valid_r && data_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                stop_pend_s = 1'b0;
                if (start && !valid_r) begin
                    state_s  = ST_SCAN;
                    mask_s   = eff_mask_s;
                    sel_s    = first_ch(eff_mask_s);
                    busy_s   = 1'b1;
                    shadow_s = 4'b0000;
                    cnt_s    = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                stop_pend_s = stop_pend_r | (CONTINUOUS & stop);
                if (cnt_r == SETTLE_M1) begin
                    cnt_s = 4'd0;
                    if (above_s == 4'b0000) begin
                        dout_s    = shadow_smp_s;
                        valid_s   = 1'b1;
                        // a transfer on this edge consumes the old word, so no overrun
                        overrun_s = valid_r & ~data_ready;
                        if (CONTINUOUS && !(stop_pend_r || stop)) begin
                            sel_s    = first_ch(mask_r);
                            shadow_s = 4'b0000;
                        end else begin
                            state_s     = ST_IDLE;
                            busy_s      = 1'b0;
                            stop_pend_s = 1'b0;
                            shadow_s    = shadow_smp_s;
                        end
                    end else begin
                        shadow_s = shadow_smp_s;
                        sel_s    = first_ch(above_s);
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                busy_s      = 1'b0;
                stop_pend_s = 1'b0;
                cnt_s       = 4'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mask_r      <= 4'b0000;
            cnt_r       <= 4'd0;
            sel_r       <= 2'd0;
            shadow_r    <= 4'b0000;
            dout_r      <= 4'b0000;
            valid_r     <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
            stop_pend_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            mask_r      <= mask_s;
            cnt_r       <= cnt_s;
            sel_r       <= sel_s;
            shadow_r    <= shadow_s;
            dout_r      <= dout_s;
            valid_r     <= valid_s;
            overrun_r   <= overrun_s;
            busy_r      <= busy_s;
            stop_pend_r <= stop_pend_s;
        end
    end

    assign S          = sel_r;
    assign busy       = busy_r;
    assign data_out   = dout_r;
    assign data_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: three sequencer instances (one-shot SETTLE=1, one-shot SETTLE=3, continuous SETTLE=1)
// each driving a behavioural 4:1 mux; results checked against a scoreboard queue.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start0, stop0, Y0, dr0, busy0, dv0, ov0;
    logic [3:0] mask0, I0, dout0;
    logic [1:0] S0;
    logic       start1, stop1, Y1, dr1, busy1, dv1, ov1;
    logic [3:0] mask1, I1, dout1;
    logic [1:0] S1;
    logic       start2, stop2, Y2, dr2, busy2, dv2, ov2;
    logic [3:0] mask2, I2, dout2;
    logic [1:0] S2;

    assign Y0 = I0[S0];
    assign Y1 = I1[S1];
    assign Y2 = I2[S2];

    mux_scan_sequencer #(.SETTLE(1), .CONTINUOUS(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .ch_mask(mask0), .S(S0), .Y(Y0),
        .busy(busy0), .data_out(dout0), .data_valid(dv0), .data_ready(dr0), .overrun(ov0));
    mux_scan_sequencer #(.SETTLE(3), .CONTINUOUS(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .ch_mask(mask1), .S(S1), .Y(Y1),
        .busy(busy1), .data_out(dout1), .data_valid(dv1), .data_ready(dr1), .overrun(ov1));
    mux_scan_sequencer #(.SETTLE(1), .CONTINUOUS(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .ch_mask(mask2), .S(S2), .Y(Y2),
        .busy(busy2), .data_out(dout2), .data_valid(dv2), .data_ready(dr2), .overrun(ov2));

    int tests = 0;
    int fails = 0;
    logic [3:0] sb_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 16'(obs), 16'(e));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic cur_valid(input int idx);
        case (idx)
            0:       cur_valid = dv0;
            1:       cur_valid = dv1;
            default: cur_valid = dv2;
        endcase
    endfunction

    function automatic logic [3:0] cur_data(input int idx);
        case (idx)
            0:       cur_data = dout0;
            1:       cur_data = dout1;
            default: cur_data = dout2;
        endcase
    endfunction

    // Called just after the start edge; counts edges until the result appears (bounded).
    task automatic wait_valid(input int idx, input int exp_lat, input string tag);
        int n = 0;
        while (!cur_valid(idx) && n < 100) begin
            step(1);
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'(exp_lat));
        sb_pop({tag, "_data"}, cur_data(idx));
    endtask

    initial begin
        rst = 1'b1;
        {start0, stop0, dr0, start1, stop1, dr1, start2, stop2, dr2} = 9'b0;
        {mask0, I0, mask1, I1, mask2, I2} = 24'b0;
        step(1);
        chk("rst_u0", 16'({S0, busy0, dv0, ov0, dout0}), 16'd0);
        chk("rst_u1", 16'({S1, busy1, dv1, ov1, dout1}), 16'd0);
        chk("rst_u2", 16'({S2, busy2, dv2, ov2, dout2}), 16'd0);
        step(1);
        rst = 1'b0;
        step(1);

        // one-shot, SETTLE=1, all channels
        I0 = 4'b1010; mask0 = 4'b1111; start0 = 1'b1;
        sb_q.push_back(4'b1010);
        step(1);
        start0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t1_S", 16'(S0), 16'(c));
            chk("t1_busy", 16'(busy0), 16'd1);
            chk("t1_dv_low", 16'(dv0), 16'd0);
            step(1);
        end
        chk("t1_dv", 16'(dv0), 16'd1);
        chk("t1_busy_end", 16'(busy0), 16'd0);
        chk("t1_S_hold", 16'(S0), 16'd3);
        sb_pop("t1_data", dout0);

        // SETTLE=3, sparse mask
        I1 = 4'b1111; mask1 = 4'b0101; start1 = 1'b1;
        sb_q.push_back(4'b0101);
        step(1);
        start1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("t2_S", 16'(S1), (c < 3) ? 16'd0 : 16'd2);
            chk("t2_dv_low", 16'(dv1), 16'd0);
            step(1);
        end
        chk("t2_dv", 16'(dv1), 16'd1);
        chk("t2_busy_end", 16'(busy1), 16'd0);
        sb_pop("t2_data", dout1);

        // start ignored while a result is pending
        I0 = 4'b1111; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(2);
        chk("t3_busy_ign", 16'(busy0), 16'd0);
        chk("t3_S_ign", 16'(S0), 16'd3);
        chk("t3_dv_held", 16'(dv0), 16'd1);
        chk("t3_dout_held", 16'(dout0), 16'(4'b1010));
        dr0 = 1'b1;
        step(1);
        chk("t3_dv_drop", 16'(dv0), 16'd0);
        dr0 = 1'b0;
        mask0 = 4'b0011; I0 = 4'b0101; start0 = 1'b1;
        sb_q.push_back(4'b0001);
        step(1);
        start0 = 1'b0;
        chk("t3_busy_new", 16'(busy0), 16'd1);
        wait_valid(0, 2, "t3");
        dr0 = 1'b1;
        step(1);
        dr0 = 1'b0;
        // empty mask means all channels; mid-scan mask change is ignored
        mask0 = 4'b0000; I0 = 4'b1100; start0 = 1'b1;
        sb_q.push_back(4'b1100);
        step(1);
        start0 = 1'b0;
        mask0 = 4'b0001;
        wait_valid(0, 4, "t3m0");
        dr0 = 1'b1;
        step(1);
        chk("t3m0_drain", 16'(dv0), 16'd0);
        dr0 = 1'b0;

        // continuous mode with overrun, then stop
        mask2 = 4'b1111; I2 = 4'b0011; start2 = 1'b1;
        sb_q.push_back(4'b0011);
        step(1);
        start2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t4_S1", 16'(S2), 16'(c));
            step(1);
        end
        chk("t4_dv1", 16'(dv2), 16'd1);
        chk("t4_wrap", 16'(S2), 16'd0);
        chk("t4_busy", 16'(busy2), 16'd1);
        chk("t4_ov_none", 16'(ov2), 16'd0);
        sb_pop("t4_data1", dout2);
        I2 = 4'b1100;
        sb_q.push_back(4'b1100);
        for (int c = 1; c < 4; c++) begin
            step(1);
            chk("t4_S2", 16'(S2), 16'(c));
        end
        step(1);
        chk("t4_ov", 16'(ov2), 16'd1);
        chk("t4_wrap2", 16'(S2), 16'd0);
        sb_pop("t4_data2", dout2);
        step(1);
        chk("t4_ov_pulse", 16'(ov2), 16'd0);
        chk("t5_S", 16'(S2), 16'd1);
        I2 = 4'b0110;
        sb_q.push_back(4'b0110);
        stop2 = 1'b1;
        step(1);
        stop2 = 1'b0;
        chk("t5_busy_mid", 16'(busy2), 16'd1);
        step(1);
        chk("t5_S3", 16'(S2), 16'd3);
        dr2 = 1'b1;
        step(1);
        chk("t5_dv_new_wins", 16'(dv2), 16'd1);
        chk("t5_ov_xfer", 16'(ov2), 16'd0);
        chk("t5_busy_off", 16'(busy2), 16'd0);
        sb_pop("t5_data", dout2);
        step(1);
        chk("t5_dv_drop", 16'(dv2), 16'd0);
        dr2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t5_idle_S", 16'(S2), 16'd3);
            chk("t5_idle_busy", 16'(busy2), 16'd0);
            step(1);
        end

        // reset mid-scan
        mask0 = 4'b1111; I0 = 4'b1111; start0 = 1'b1;
        sb_q.push_back(4'b1111);
        step(1);
        start0 = 1'b0;
        step(2);
        chk("t6_S_pre", 16'(S0), 16'd2);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_now", 16'({S0, busy0, dv0, ov0, dout0}), 16'd0);
        sb_q.delete();
        step(1);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t6_no_dv", 16'(dv0), 16'd0);
            step(1);
        end
        I0 = 4'b0110; start0 = 1'b1;
        sb_q.push_back(4'b0110);
        step(1);
        start0 = 1'b0;
        wait_valid(0, 4, "t6");

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
